// File: rtl/msg_scan_driver.sv
// msg_scan_driver: multiplexed digit scanner that shows one of eight built-in messages.
// Blinking is compiled in only when MSG_SCAN_BLINK_EN is defined; otherwise blink_on is ignored.
module msg_scan_driver #(
  parameter int NDIGITS      = 4,
  parameter int CHAR_W       = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2:0]         msg_sel,
  input  logic               msg_load,
  input  logic               blank,
  input  logic               blink_on,
  output logic [NDIGITS-1:0] digit_en,
  output logic [CHAR_W-1:0]  char_code,
  output logic               frame_tick
);

  localparam int PRE_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CHAR_W-1:0] BL       = '1;
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NDIGITS - 1);

  typedef logic [CHAR_W-1:0] code_t;

  logic [PRE_W-1:0]    pre;
  logic [IDX_W-1:0]    idx;
  logic [4*CHAR_W-1:0] msg;
  logic                pre_tc;
  logic                disp_on;
  code_t               cur_code;

  function automatic code_t gl(input logic [3:0] g);
    return code_t'(g);
  endfunction

  // packed as {digit3, digit2, digit1, digit0}
  function automatic logic [4*CHAR_W-1:0] lookup(input logic [2:0] sel);
    logic [4*CHAR_W-1:0] r;
    case (sel)
      3'd1:    r = {gl(4'h8), gl(4'h0), gl(4'hA), gl(4'h3)};
      3'd2:    r = {BL,       gl(4'h0), gl(4'h2), gl(4'h2)};
      3'd3:    r = {BL,       gl(4'h8), gl(4'h9), gl(4'h1)};
      3'd4:    r = {BL,       gl(4'h4), gl(4'h5), gl(4'h9)};
      3'd5:    r = {BL,       gl(4'h2), gl(4'hC), gl(4'hA)};
      default: r = {4{BL}};
    endcase
    return r;
  endfunction

  assign pre_tc     = (pre == PRE_LAST);
  assign frame_tick = pre_tc && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      idx <= '0;
    end else begin
      pre <= pre_tc ? '0 : pre + PRE_W'(1);
      if (pre_tc) idx <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
    end
  end

  // loads never touch the scan counters, so the display keeps its cadence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        msg <= {4{BL}};
    else if (msg_load) msg <= lookup(msg_sel);
  end

`ifdef MSG_SCAN_BLINK_EN
  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0] FC_LAST = FC_W'(BLINK_FRAMES - 1);

  logic [FC_W-1:0] fcnt;
  logic            phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (!blink_on) begin
      fcnt  <= '0;
      phase <= 1'b1;
    end else if (frame_tick) begin
      if (fcnt == FC_LAST) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FC_W'(1);
      end
    end
  end

  // blink_on low gates the display back on without waiting for the phase register
  assign disp_on = ~blank & (~blink_on | phase);
`else
  logic unused_blink;
  assign unused_blink = blink_on & (BLINK_FRAMES > 0);
  assign disp_on      = ~blank;
`endif

  // positions at or above 4 have no table entry and stay blank
  always_comb begin
    cur_code = BL;
    for (int i = 0; i < 4; i++) begin
      if (int'(idx) == i) cur_code = msg[i*CHAR_W +: CHAR_W];
    end
  end

  assign digit_en  = disp_on ? (NDIGITS'(1) << idx) : '0;
  assign char_code = disp_on ? cur_code : BL;

endmodule

// File: tb/tb_msg_scan_driver.sv
// Bench for msg_scan_driver with NDIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2.
// k counts clock edges since reset release; expected scan position is derived from it.
module tb_msg_scan_driver;
  localparam int ND = 4;
  localparam int CW = 4;
  localparam int SD = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [2:0]    msg_sel = 3'd0;
  logic          msg_load = 1'b0;
  logic          blank = 1'b0;
  logic          blink_on = 1'b0;
  logic [ND-1:0] digit_en;
  logic [CW-1:0] char_code;
  logic          frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int k;

  typedef struct packed {
    logic [2:0]  sel;
    logic        load;
    logic [15:0] codes;
  } vec_t;

  vec_t        vecs [9];
  logic [15:0] msg_ref [8];
  logic [15:0] cur;
  int          hold_sel [4];

  msg_scan_driver #(
    .NDIGITS(ND), .CHAR_W(CW), .SCAN_DIV(SD), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .msg_sel(msg_sel), .msg_load(msg_load),
    .blank(blank), .blink_on(blink_on), .digit_en(digit_en),
    .char_code(char_code), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k <= 0;
    else        k <= k + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at k=%0d t=%0t: got %h, expected %h", name, k, $time, act, exp);
    end
  endtask

  task automatic check_cycle(input logic [15:0] codes, input logic on);
    int idx;
    int pre;
    idx = (k / SD) % ND;
    pre = k % SD;
    chk("digit_en",   {28'd0, digit_en},  on ? (32'd1 << idx) : 32'd0);
    chk("char_code",  {28'd0, char_code}, on ? {28'd0, codes[idx*4 +: 4]} : 32'hF);
    chk("frame_tick", {31'd0, frame_tick}, (pre == SD-1 && idx == ND-1) ? 32'd1 : 32'd0);
  endtask

  task automatic step_check(input logic [15:0] codes, input logic on);
    @(negedge clk);
    #1 check_cycle(codes, on);
  endtask

  initial begin
    vecs[0] = '{sel: 3'd1, load: 1'b1, codes: 16'h80A3};
    vecs[1] = '{sel: 3'd6, load: 1'b0, codes: 16'h80A3};
    vecs[2] = '{sel: 3'd2, load: 1'b1, codes: 16'hF022};
    vecs[3] = '{sel: 3'd3, load: 1'b1, codes: 16'hF891};
    vecs[4] = '{sel: 3'd0, load: 1'b0, codes: 16'hF891};
    vecs[5] = '{sel: 3'd4, load: 1'b1, codes: 16'hF459};
    vecs[6] = '{sel: 3'd5, load: 1'b1, codes: 16'hF2CA};
    vecs[7] = '{sel: 3'd7, load: 1'b1, codes: 16'hFFFF};
    vecs[8] = '{sel: 3'd1, load: 1'b1, codes: 16'h80A3};
    msg_ref[0] = 16'hFFFF; msg_ref[1] = 16'h80A3; msg_ref[2] = 16'hF022; msg_ref[3] = 16'hF891;
    msg_ref[4] = 16'hF459; msg_ref[5] = 16'hF2CA; msg_ref[6] = 16'hFFFF; msg_ref[7] = 16'hFFFF;
    hold_sel[0] = 2; hold_sel[1] = 3; hold_sel[2] = 4; hold_sel[3] = 5;

    // reset values, then free-running scan of a blank message
    repeat (2) @(negedge clk);
    #1 check_cycle(16'hFFFF, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_cycle(16'hFFFF, 1'b1);
    for (int i = 0; i < 32; i++) step_check(16'hFFFF, 1'b1);

    // table: load (or ignored select change), then one full frame
    cur = 16'hFFFF;
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      msg_sel  = vecs[v].sel;
      msg_load = vecs[v].load;
      #1 check_cycle(cur, 1'b1);
      @(negedge clk);
      msg_load = 1'b0;
      cur = vecs[v].codes;
      #1 check_cycle(cur, 1'b1);
      for (int i = 0; i < 16; i++) step_check(cur, 1'b1);
    end

    // load held high reloads on each edge
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      msg_sel  = 3'(hold_sel[i]);
      msg_load = 1'b1;
      #1 check_cycle(cur, 1'b1);
      cur = msg_ref[hold_sel[i]];
    end
    @(negedge clk);
    msg_load = 1'b0;
    #1 check_cycle(cur, 1'b1);

    // blank for 10 cycles straddling a frame boundary
    while ((k % 16) != 7) step_check(cur, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      blank = 1'b1;
      #1 check_cycle(cur, 1'b0);
    end
    @(negedge clk);
    blank = 1'b0;
    #1 check_cycle(cur, 1'b1);
    for (int i = 0; i < 16; i++) step_check(cur, 1'b1);

    // reset during digit 2 aborts scan and clears the message
    while ((k % 16) != 9) step_check(cur, 1'b1);
    chk("pre_reset_char", {28'd0, char_code}, {28'd0, cur[11:8]});
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_cycle(16'hFFFF, 1'b1);
    chk("reset_digit_en", {28'd0, digit_en}, 32'd1);
    @(negedge clk);
    #1 check_cycle(16'hFFFF, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    cur = 16'hFFFF;
    #1 check_cycle(cur, 1'b1);
    for (int i = 0; i < 17; i++) step_check(cur, 1'b1);

`ifdef MSG_SCAN_BLINK_EN
    // blink: on 32 clocks, off 32 clocks; dropping blink_on restores at once
    @(negedge clk);
    rst_n = 1'b0;
    blink_on = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_cycle(cur, 1'b1);
    for (int i = 0; i < 100; i++) step_check(cur, ((k / 32) % 2) == 0);
    @(negedge clk);
    blink_on = 1'b0;
    #1 check_cycle(cur, 1'b1);
    for (int i = 0; i < 8; i++) step_check(cur, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
